fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, drives the synchronous instruction memory (1-cycle read latency), and produces the IF/ID pipeline register consumed by decode. Handles decode back-pressure (`stall`) with a one-entry skid buffer and EX-stage redirects (branch/jump) with flush of all younger wrong-path fetches.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and small helpers used by the pipeline stages.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction that landed while decode stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, instr_q;

  // Next occupancy: flush wins over load, load and drain never coincide.
  always_comb begin
    valid_d = valid_q;
    if (load_i)  valid_d = 1'b1;
    if (drain_i) valid_d = 1'b0;
    if (flush_i) valid_d = 1'b0;
  end

  // Occupancy flag register; only control state is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload capture; contents are meaningless while the entry is empty.
  always_ff @(posedge clk) begin
    if (load_i && !flush_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory request issue, skid handling and IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inf_valid_q, inf_valid_d;
  logic [XLEN-1:0] inf_pc_q, inf_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;

  logic            skid_valid, skid_load, skid_drain, skid_flush;
  logic [XLEN-1:0] skid_pc, skid_instr;
  logic            issue;

  // A redirect always issues its target; otherwise stop issuing once a stalled
  // decode already has one instruction landing or parked.
  assign instr_addr = redirect_valid ? align_pc(redirect_pc) : pc_q;
  assign issue      = rst_n & (redirect_valid | ~(stall & (inf_valid_q | skid_valid)));
  assign instr_req  = issue;

  // Park the landing instruction while stalled; release it first on unstall.
  assign skid_load  = ~redirect_valid & stall & inf_valid_q;
  assign skid_drain = ~redirect_valid & ~stall & skid_valid;
  assign skid_flush = redirect_valid;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .pc_i    (inf_pc_q),
    .instr_i (instr),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Next PC / in-flight tag and IF/ID load selection.
  always_comb begin
    pc_d         = pc_q;
    inf_valid_d  = issue;
    inf_pc_d     = inf_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (issue) begin
      pc_d     = instr_addr + PC_STEP;
      inf_pc_d = instr_addr;
    end
    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = skid_instr;
        ifid_pc_d    = skid_pc;
      end else if (inf_valid_q) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = instr;
        ifid_pc_d    = inf_pc_q;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inf_valid_q  <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      inf_valid_q  <= inf_valid_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  // In-flight address tag; only meaningful while inf_valid_q is set.
  always_ff @(posedge clk) begin
    inf_pc_q <= inf_pc_d;
  end

  assign if_id_valid = ifid_valid_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_pc    = ifid_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous memory returning mem[a] = a.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr_req      (instr_req),
    .instr          (instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  always #5 clk = ~clk;

  // Memory: 1-cycle read latency, data equals address; idle cycles return junk.
  always @(posedge clk) begin
    if (instr_req) instr <= instr_addr;
    else           instr <= 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        chk;   // compare if_id_pc / if_id_instr this row
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check just after.
  task automatic apply(input vec_t v, input int row);
    @(negedge clk);
    rst_n          = v.rst_n;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
    cmp("instr_req", row, {31'd0, instr_req}, {31'd0, v.req});
    cmp("instr_addr", row, instr_addr, v.addr);
    cmp("if_id_valid", row, {31'd0, if_id_valid}, {31'd0, v.vld});
    if (v.chk) begin
      cmp("if_id_pc", row, if_id_pc, v.pc);
      cmp("if_id_instr", row, if_id_instr, v.ins);
    end
    if (rst_n && dut.skid_valid && dut.inf_valid_q) begin
      errors++;
      $display("FAIL skid_inf_overlap row %0d: got 1 expected 0", row);
    end
    if (rst_n && dut.skid_load && dut.skid_valid) begin
      errors++;
      $display("FAIL skid_overwrite row %0d: got 1 expected 0", row);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t tbl [15];

  initial begin
    // rst stall rv rpc | req addr vld chk pc ins
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 1'b1, 32'h0,   NOP};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 1'b1, 32'h0,   NOP};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 1'b1, 32'h100, 32'h100};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 1'b1, 32'h104, 32'h104};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 1'b1, 32'h108, 32'h108};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 1'b1, 32'h108, 32'h108};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 1'b1, 32'h108, 32'h108};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 1'b1, 32'h108, 32'h108};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h114, 1'b1, 1'b1, 32'h10C, 32'h10C};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h118, 1'b1, 1'b1, 32'h110, 32'h110};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 1'b1, 32'h114, 32'h114};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h408, 1'b1, 1'b1, 32'h400, 32'h400};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40C, 1'b1, 1'b1, 32'h404, 32'h404};

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    // Reset, streaming, 3-cycle stall with skid, redirect to 0x400.
    for (int i = 0; i < 15; i++) apply(tbl[i], i);

    // Fill skid, then redirect to misaligned 0x402 together with stall.
    apply('{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h410, 1'b1, 1'b1, 32'h408, 32'h408}, 100);
    apply('{1'b1, 1'b1, 1'b1, 32'h402, 1'b1, 32'h400, 1'b1, 1'b1, 32'h408, 32'h408}, 101);
    apply('{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h404, 1'b0, 1'b0, 32'h0,   32'h0},   102);
    apply('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 1'b0, 32'h0,   32'h0},   103);
    apply('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h408, 1'b1, 1'b1, 32'h400, 32'h400}, 104);
    apply('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40C, 1'b1, 1'b1, 32'h404, 32'h404}, 105);

    // PC wrap past the top of the address space.
    apply('{1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h408, 32'h408}, 200);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0}, 201);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8}, 202);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC}, 203);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h0, 32'h0}, 204);

    // Reset while stalled with a full skid.
    apply('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h4, 32'h4}, 300);
    apply('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h4, 32'h4}, 301);
    apply('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 1'b1, 32'h0, NOP}, 302);
    cmp("skid_valid_after_rst", 302, {31'd0, dut.skid_valid}, 32'd0);
    cmp("inf_valid_after_rst", 302, {31'd0, dut.inf_valid_q}, 32'd0);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h0, NOP}, 303);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0}, 304);
    apply('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h100, 32'h100}, 305);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
